vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 143 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: sync, data-enable and incremental framebuffer address for an integer-scaled image.
// Outputs are registered with one pixel of latency. Optional letterbox window via VGA_TIMING_WINDOW_EN.
module vga_timing_gen #(
  parameter int H_VIS       = 640,
  parameter int H_FP        = 120,
  parameter int H_SYNC      = 128,
  parameter int H_BP        = 168,
  parameter int V_VIS       = 576,
  parameter int V_FP        = 13,
  parameter int V_SYNC      = 4,
  parameter int V_BP        = 35,
  parameter int HSYNC_POL   = 1,
  parameter int VSYNC_POL   = 1,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_WIDTH    = 160,
  parameter int ADDR_W      = 15,
  parameter int CW          = 11
`ifdef VGA_TIMING_WINDOW_EN
  ,
  parameter int WIN_X       = 0,
  parameter int WIN_Y       = 0,
  parameter int WIN_W       = H_VIS,
  parameter int WIN_H       = V_VIS
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_ce,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              line_start,
  output logic              frame_start,
  output logic [CW-1:0]     h_count,
  output logic [CW-1:0]     v_count
`ifdef VGA_TIMING_WINDOW_EN
  ,
  output logic              fb_valid
`endif
);

`ifndef VGA_TIMING_WINDOW_EN
  localparam int WIN_X = 0;
  localparam int WIN_Y = 0;
  localparam int WIN_W = H_VIS;
  localparam int WIN_H = V_VIS;
`endif

  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VIS + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VIS + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int PW       = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
  localparam logic [PW-1:0] PH_MAX = PW'((1 << SCALE_SHIFT) - 1);
  localparam logic HP = (HSYNC_POL != 0);
  localparam logic VP = (VSYNC_POL != 0);

  logic [CW-1:0]     h, v;
  logic [PW-1:0]     h_ph, v_ph;
  logic [ADDR_W-1:0] col, line_base;

  logic h_last, v_last, hs_act, vs_act, vis, in_win;

  always_comb begin
    h_last = (h == CW'(H_TOT - 1));
    v_last = (v == CW'(V_TOT - 1));
    hs_act = (int'(h) >= HS_START) && (int'(h) < HS_END);
    vs_act = (int'(v) >= VS_START) && (int'(v) < VS_END);
    vis    = (int'(h) < H_VIS) && (int'(v) < V_VIS);
    in_win = vis &&
             (int'(h) >= WIN_X) && (int'(h) < WIN_X + WIN_W) &&
             (int'(v) >= WIN_Y) && (int'(v) < WIN_Y + WIN_H);
  end

  // Phase counters replace the (pos - WIN) >> SCALE_SHIFT division; col/line_base track it without a multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      h           <= '0;
      v           <= '0;
      h_ph        <= '0;
      v_ph        <= '0;
      col         <= '0;
      line_base   <= '0;
      hsync       <= ~HP;
      vsync       <= ~VP;
      de          <= 1'b0;
      fb_addr     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      h_count     <= '0;
      v_count     <= '0;
`ifdef VGA_TIMING_WINDOW_EN
      fb_valid    <= 1'b0;
`endif
    end else if (pix_ce) begin
      hsync       <= hs_act ? HP : ~HP;
      vsync       <= vs_act ? VP : ~VP;
      de          <= vis;
      fb_addr     <= in_win ? (line_base + col) : '0;
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
      h_count     <= h;
      v_count     <= v;
`ifdef VGA_TIMING_WINDOW_EN
      fb_valid    <= in_win;
`endif
      if (h_last) begin
        h    <= '0;
        h_ph <= '0;
        col  <= '0;
        if (v_last) begin
          v         <= '0;
          v_ph      <= '0;
          line_base <= '0;
        end else begin
          v <= v + 1'b1;
          if ((int'(v) >= WIN_Y) && (int'(v) + 1 < V_VIS)) begin
            if (v_ph == PH_MAX) begin
              v_ph      <= '0;
              line_base <= line_base + ADDR_W'(FB_WIDTH);
            end else begin
              v_ph <= v_ph + 1'b1;
            end
          end
        end
      end else begin
        h <= h + 1'b1;
        if (int'(h) >= WIN_X) begin
          if (h_ph == PH_MAX) begin
            h_ph <= '0;
            col  <= col + 1'b1;
          end else begin
            h_ph <= h_ph + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small raster; a second instance checks inverted sync polarity.
module tb_vga_timing_gen;
  localparam int HV = 8, HF = 2, HS = 2, HB = 2;
  localparam int VV = 4, VF = 1, VS = 1, VB = 1;
  localparam int S = 1, FBW = 4, AW = 15, CW = 11;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic clk = 1'b0;
  logic rst, pix_ce;
  logic hsync, vsync, de, line_start, frame_start;
  logic [AW-1:0] fb_addr;
  logic [CW-1:0] h_count, v_count;
  logic hsync_b, vsync_b, de_b, line_start_b, frame_start_b;
  logic [AW-1:0] fb_addr_b;
  logic [CW-1:0] h_count_b, v_count_b;
`ifdef VGA_TIMING_WINDOW_EN
  logic fb_valid, fb_valid_b;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1), .VSYNC_POL(1), .SCALE_SHIFT(S), .FB_WIDTH(FBW),
    .ADDR_W(AW), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .hsync(hsync), .vsync(vsync), .de(de), .fb_addr(fb_addr),
    .line_start(line_start), .frame_start(frame_start),
    .h_count(h_count), .v_count(v_count)
`ifdef VGA_TIMING_WINDOW_EN
    , .fb_valid(fb_valid)
`endif
  );

  vga_timing_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(0), .VSYNC_POL(0), .SCALE_SHIFT(S), .FB_WIDTH(FBW),
    .ADDR_W(AW), .CW(CW)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .fb_addr(fb_addr_b),
    .line_start(line_start_b), .frame_start(frame_start_b),
    .h_count(h_count_b), .v_count(v_count_b)
`ifdef VGA_TIMING_WINDOW_EN
    , .fb_valid(fb_valid_b)
`endif
  );

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic          ls;
    logic          fs;
    logic [AW-1:0] addr;
    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int checks = 0;
  int errors = 0;
  int mh = 0, mv = 0;
  int cyc = 0;
  int last_fs = -1;
  int fs_seen = 0;

  function automatic exp_t model(input int h, input int v);
    exp_t r;
    r.hs   = (h >= HV + HF) && (h < HV + HF + HS);
    r.vs   = (v >= VV + VF) && (v < VV + VF + VS);
    r.de   = (h < HV) && (v < VV);
    r.addr = r.de ? AW'((v >> S) * FBW + (h >> S)) : '0;
    r.ls   = (h == 0);
    r.fs   = (h == 0) && (v == 0);
    r.hc   = CW'(h);
    r.vc   = CW'(v);
    return r;
  endfunction

  task automatic advance();
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
  endtask

  task automatic check_out(input exp_t x, input string tag);
    checks++; assert (hsync === x.hs) else begin errors++; $error("FAIL %s hsync got %b exp %b", tag, hsync, x.hs); end
    checks++; assert (vsync === x.vs) else begin errors++; $error("FAIL %s vsync got %b exp %b", tag, vsync, x.vs); end
    checks++; assert (de === x.de) else begin errors++; $error("FAIL %s de got %b exp %b", tag, de, x.de); end
    checks++; assert (fb_addr === x.addr) else begin errors++; $error("FAIL %s fb_addr got %0d exp %0d", tag, fb_addr, x.addr); end
    checks++; assert (line_start === x.ls) else begin errors++; $error("FAIL %s line_start got %b exp %b", tag, line_start, x.ls); end
    checks++; assert (frame_start === x.fs) else begin errors++; $error("FAIL %s frame_start got %b exp %b", tag, frame_start, x.fs); end
    checks++; assert (h_count === x.hc) else begin errors++; $error("FAIL %s h_count got %0d exp %0d", tag, h_count, x.hc); end
    checks++; assert (v_count === x.vc) else begin errors++; $error("FAIL %s v_count got %0d exp %0d", tag, v_count, x.vc); end
    checks++; assert (hsync_b === ~x.hs) else begin errors++; $error("FAIL %s hsync_lowpol got %b exp %b", tag, hsync_b, ~x.hs); end
    checks++; assert (vsync_b === ~x.vs) else begin errors++; $error("FAIL %s vsync_lowpol got %b exp %b", tag, vsync_b, ~x.vs); end
`ifdef VGA_TIMING_WINDOW_EN
    checks++; assert (fb_valid === x.de) else begin errors++; $error("FAIL %s fb_valid got %b exp %b", tag, fb_valid, x.de); end
`endif
  endtask

  task automatic step(input logic ce);
    exp_t e;
    @(negedge clk);
    rst    = 1'b0;
    pix_ce = ce;
    if (ce) begin
      q.push_back(model(mh, mv));
      advance();
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ce) begin
      checks++;
      assert (q.size() != 0) else begin errors++; $error("FAIL scoreboard_empty got %0d exp 1", q.size()); end
      if (q.size() != 0) begin
        e    = q.pop_front();
        last = e;
        check_out(e, "run");
      end
    end else begin
      check_out(last, "hold");
    end
  endtask

  task automatic do_reset(input logic ce);
    @(negedge clk);
    rst    = 1'b1;
    pix_ce = ce;
    @(posedge clk);
    #1;
    q.delete();
    mh   = 0;
    mv   = 0;
    last = '0;
    check_out(last, "reset");
  endtask

  initial begin
    rst    = 1'b1;
    pix_ce = 1'b0;
    do_reset(1'b0);
    do_reset(1'b1);
    step(1'b0);

    // Two full frames at full rate; frame_start must recur every HT*VT clocks.
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step(1'b1);
      if (frame_start === 1'b1) begin
        fs_seen++;
        if (last_fs >= 0) begin
          checks++;
          assert (cyc - last_fs == HT * VT) else begin errors++; $error("FAIL frame_period got %0d exp %0d", cyc - last_fs, HT * VT); end
        end
        last_fs = cyc;
      end
    end
    checks++;
    assert (fs_seen == 2) else begin errors++; $error("FAIL frame_start_count got %0d exp 2", fs_seen); end

    for (int i = 0; i < 120; i++) step((i % 4 == 0) || (i % 4 == 3));

    for (int i = 0; i < 2 * HT * VT && !(mh == 5 && mv == 2); i++) step(1'b1);
    checks++;
    assert (mh == 5 && mv == 2) else begin errors++; $error("FAIL reach_mid_frame got (%0d,%0d) exp (5,2)", mh, mv); end
    do_reset(1'b1);
    step(1'b0);
    step(1'b1);
    checks++;
    assert (frame_start === 1'b1 && de === 1'b1) else begin errors++; $error("FAIL first_after_reset got fs=%b de=%b exp 1 1", frame_start, de); end
    for (int i = 0; i < 3 * HT; i++) step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
